// File: rtl/tank_pump_controller.sv
// tank_pump_controller: debounced level-driven pump sequencer with hysteresis, holdoff, dry-run fault
module tank_pump_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIN_OFF_CYCLES  = 1024,
  parameter int MAX_RUN_CYCLES  = 65536,
  parameter int BUZZ_PERIOD     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] level,
  input  logic       level_valid,
  input  logic       manual_stop,
  input  logic       alarm_ack,
  output logic       motor,
  output logic       led,
  output logic       buzzer,
  output logic       fault,
  output logic [2:0] state
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_NEAR = 3'd2, S_HOLD = 3'd3, S_FAULT = 3'd4;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RUN_CYCLES + 1);
  localparam int OW = $clog2(MIN_OFF_CYCLES + 1);
  localparam int BW = $clog2(BUZZ_PERIOD + 1);
  localparam logic [DW-1:0] DB_DONE  = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] RUN_LAST = RW'(MAX_RUN_CYCLES - 1);
  localparam logic [OW-1:0] OFF_LAST = OW'(MIN_OFF_CYCLES - 1);
  localparam logic [BW-1:0] BUZ_LAST = BW'(BUZZ_PERIOD - 1);
  logic [1:0] raw, stable_level;
  logic [DW-1:0] db_cnt, db_next;
  logic [RW-1:0] run_timer;
  logic [OW-1:0] off_timer;
  logic [BW-1:0] buzz_cnt;
  logic buzz_on, timeout, low, full, running;
  logic [2:0] nxt;
  assign timeout = run_timer == RUN_LAST;
  assign low     = stable_level <= 2'd1;
  assign full    = stable_level == 2'd3;
  assign running = state == S_FILL || state == S_NEAR;
  assign motor   = running;
  assign led     = low;
  assign fault   = state == S_FAULT;
  assign buzzer  = fault || (state == S_NEAR && buzz_on);
  // Saturating run length of identical raw samples
  always_comb db_next = (level != raw) ? DW'(1) : (db_cnt == DB_DONE) ? db_cnt : db_cnt + DW'(1);
  // Next state: timeout outranks manual stop, which outranks level
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = (low && !manual_stop) ? S_FILL : S_IDLE;
      S_FILL:  nxt = timeout ? S_FAULT : (manual_stop || full) ? S_HOLD : (stable_level == 2'd2) ? S_NEAR : S_FILL;
      S_NEAR:  nxt = timeout ? S_FAULT : (manual_stop || full) ? S_HOLD : low ? S_FILL : S_NEAR;
      S_HOLD:  nxt = (off_timer == OFF_LAST) ? S_IDLE : S_HOLD;
      S_FAULT: nxt = alarm_ack ? S_HOLD : S_FAULT;
      default: nxt = S_IDLE;
    endcase
  end
  // Debounce: only valid samples advance the filter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      raw          <= 2'd3;
      db_cnt       <= '0;
      stable_level <= 2'd3;
    end else if (level_valid) begin
      raw    <= level;
      db_cnt <= db_next;
      if (db_next == DB_DONE) stable_level <= level;
    end
  // State register plus run, off and buzzer timers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      run_timer <= '0;
      off_timer <= '0;
      buzz_cnt  <= '0;
      buzz_on   <= 1'b0;
    end else begin
      state     <= nxt;
      run_timer <= (state == S_IDLE && nxt == S_FILL) ? '0 : (running && !timeout) ? run_timer + RW'(1) : run_timer;
      off_timer <= (nxt == S_HOLD && state != S_HOLD) ? '0 : (state == S_HOLD && off_timer != OFF_LAST) ? off_timer + OW'(1) : off_timer;
      buzz_cnt  <= (state != S_NEAR || buzz_cnt == BUZ_LAST) ? '0 : buzz_cnt + BW'(1);
      buzz_on   <= (state != S_NEAR) ? 1'b1 : (buzz_cnt == BUZ_LAST) ? ~buzz_on : buzz_on;
    end
endmodule

// File: tb/tb_tank_pump_controller.sv
// tb_tank_pump_controller: directed checks of debounce, hysteresis, holdoff, timeout, stop and reset
module tb_tank_pump_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] level = 2'd0;
  logic level_valid = 1'b1, manual_stop = 1'b0, alarm_ack = 1'b0;
  logic motor, led, buzzer, fault;
  logic [2:0] state;
  int total = 0, bad = 0;
  tank_pump_controller #(.DEBOUNCE_CYCLES(4), .MIN_OFF_CYCLES(8), .MAX_RUN_CYCLES(50), .BUZZ_PERIOD(2)) dut (
    .clk(clk), .rst(rst), .level(level), .level_valid(level_valid), .manual_stop(manual_stop),
    .alarm_ack(alarm_ack), .motor(motor), .led(led), .buzzer(buzzer), .fault(fault), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    logic [4:0] pat;
    pat = 5'b10011;
    #11;
    chk("rst_state", state, 0);
    chk("rst_motor", motor, 0);
    chk("rst_led", led, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t1_motor_off", motor, 0);
    end
    step(1);
    chk("t1_fill", state, 1);
    chk("t1_motor_on", motor, 1);
    chk("t1_led", led, 1);
    level = 2'd3;
    step(1);
    level = 2'd0;
    step(1);
    chk("t2_glitch_state", state, 1);
    chk("t2_glitch_led", led, 1);
    chk("t2_glitch_motor", motor, 1);
    level = 2'd2;
    step(4);
    chk("t3_still_fill", state, 1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t3_near", state, 2);
      chk("t3_buzz", buzzer, pat[i]);
    end
    level = 2'd3;
    step(5);
    chk("t3_hold", state, 3);
    chk("t3_hold_motor", motor, 0);
    level = 2'd0;
    step(7);
    chk("t3_hold_ignores", state, 3);
    step(1);
    chk("t3_idle", state, 0);
    step(1);
    chk("t3_refill", state, 1);
    level = 2'd1;
    step(49);
    chk("t4_fill49", state, 1);
    alarm_ack = 1'b1;
    step(1);
    chk("t4_fault", state, 4);
    chk("t4_fault_flag", fault, 1);
    chk("t4_fault_buzz", buzzer, 1);
    chk("t4_fault_motor", motor, 0);
    alarm_ack = 1'b0;
    step(1);
    chk("t4_entry_ack_ignored", state, 4);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    chk("t4_ack_hold", state, 3);
    chk("t4_ack_fault", fault, 0);
    level = 2'd2;
    step(7);
    chk("t5_hold", state, 3);
    step(1);
    chk("t5_idle", state, 0);
    step(2);
    chk("t5_hysteresis", state, 0);
    chk("t5_led_near", led, 0);
    level = 2'd1;
    step(4);
    chk("t5_idle_deb", state, 0);
    step(1);
    chk("t5_fill", state, 1);
    level = 2'd2;
    step(5);
    chk("t5_near", state, 2);
    manual_stop = 1'b1;
    level = 2'd0;
    step(1);
    chk("t5_stop_hold", state, 3);
    step(8);
    chk("t5_stop_idle", state, 0);
    step(3);
    chk("t5_stop_stay", state, 0);
    chk("t5_stop_motor", motor, 0);
    manual_stop = 1'b0;
    step(1);
    chk("t5_release_fill", state, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_motor", motor, 0);
    chk("t6_async_state", state, 0);
    chk("t6_async_led", led, 0);
    rst = 1'b0;
    level = 2'd1;
    step(2);
    level_valid = 1'b0;
    level = 2'd0;
    step(2);
    level_valid = 1'b1;
    level = 2'd1;
    step(2);
    chk("t6_idle", state, 0);
    chk("t6_led", led, 1);
    step(1);
    chk("t6_fill", state, 1);
    chk("t6_motor", motor, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
